// File: rtl/reflex_timer_multi_if.sv
// Button inputs and game-status outputs of the reflex timer.
// The master side drives the raw buttons and the slave side is the controller.
interface reflex_timer_multi_if #(
  parameter int NUM_PLAYERS = 2
);
  logic                   ready_btn;
  logic [NUM_PLAYERS-1:0] fire_btn;
  logic                   stim_led;
  logic [13:0]            result_ms;
  logic [15:0]            result_bcd;
  logic                   bcd_valid;
  logic [2:0]             winner;
  logic                   false_start;
  logic                   timeout;
  logic [13:0]            best_ms;
  logic [2:0]             state_o;

  modport master (
    output ready_btn, fire_btn,
    input  stim_led, result_ms, result_bcd, bcd_valid, winner,
           false_start, timeout, best_ms, state_o
  );

  modport slave (
    input  ready_btn, fire_btn,
    output stim_led, result_ms, result_bcd, bcd_valid, winner,
           false_start, timeout, best_ms, state_o
  );
endinterface

// File: rtl/reflex_timer_multi.sv
// Multi-player reaction-time game: debounced buttons, LFSR-random stimulus delay,
// ms timing with false-start and timeout detection, and a serial binary-to-BCD converter.
module reflex_timer_multi #(
  parameter int NUM_PLAYERS     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CYCLES_PER_MS   = 100000,
  parameter int MIN_DELAY_MS    = 1000,
  parameter int RAND_BITS       = 11,
  parameter int TIMEOUT_MS      = 9999
) (
  input logic                  clk,
  input logic                  reset,
  reflex_timer_multi_if.slave  bus
);
  localparam int NB = NUM_PLAYERS + 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
  localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DB_FIRE = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PS_LAST = PW'(CYCLES_PER_MS - 1);
  localparam logic [13:0]   T_MAX   = 14'(TIMEOUT_MS);
  localparam logic [13:0]   D_MIN   = 14'(MIN_DELAY_MS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_WAIT  = 3'd2,
    S_GO    = 3'd3,
    S_DONE  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  // Bit 0 is the ready button, bits 1.. are the fire buttons.
  logic [NB-1:0] w_raw;
  logic [NB-1:0] w_evt;
  assign w_raw = {bus.fire_btn, bus.ready_btn};

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_db
      logic          r_s1;
      logic          r_s2;
      logic [DW-1:0] r_cnt;
      always_ff @(posedge clk) begin
        if (!reset) begin
          r_s1  <= 1'b0;
          r_s2  <= 1'b0;
          r_cnt <= '0;
        end else begin
          r_s1 <= w_raw[gi];
          r_s2 <= r_s1;
          if (!r_s2)
            r_cnt <= '0;
          else if (r_cnt != DB_MAX)
            r_cnt <= r_cnt + 1'b1;
        end
      end
      // Saturation past DB_FIRE means a held button produces exactly one event.
      assign w_evt[gi] = r_s2 && (r_cnt == DB_FIRE);
    end
  endgenerate

  logic                   w_ready_evt;
  logic [NUM_PLAYERS-1:0] w_fire_evt;
  logic                   w_any_fire;
  logic [2:0]             w_low;
  assign w_ready_evt = w_evt[0];
  assign w_fire_evt  = w_evt[NB-1:1];
  assign w_any_fire  = |w_fire_evt;

  always_comb begin
    w_low = 3'd0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--)
      if (w_fire_evt[i]) w_low = 3'(i);
  end

  logic [15:0] r_lfsr;
  always_ff @(posedge clk) begin
    if (!reset) r_lfsr <= 16'hACE1;
    else        r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  state_t      r_state, w_state_next;
  logic [13:0] r_ms, r_delay, r_result, r_best;
  logic [PW-1:0] r_presc;
  logic        w_tick, w_go_enter, w_do_fault, w_do_press, w_do_tmo, w_clr_presc;
  logic        r_stim_led, r_false, r_tmo, r_load;
  logic [2:0]  r_winner;

  assign w_tick      = (r_presc == PS_LAST);
  assign w_clr_presc = (r_state == S_ARM) || w_go_enter;

  always_ff @(posedge clk) begin
    if (!reset || w_clr_presc || w_tick) r_presc <= '0;
    else                                 r_presc <= r_presc + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_go_enter   = 1'b0;
    w_do_fault   = 1'b0;
    w_do_press   = 1'b0;
    w_do_tmo     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_FAULT: if (w_ready_evt) w_state_next = S_ARM;
      S_ARM: w_state_next = S_WAIT;
      S_WAIT: begin
        if (r_ms == r_delay) begin
          w_state_next = S_GO;
          w_go_enter   = 1'b1;
        end else if (w_any_fire) begin
          w_state_next = S_FAULT;
          w_do_fault   = 1'b1;
        end
      end
      S_GO: begin
        // A press on the timeout cycle still counts as a press.
        if (w_any_fire) begin
          w_state_next = S_DONE;
          w_do_press   = 1'b1;
        end else if (r_ms == T_MAX) begin
          w_state_next = S_DONE;
          w_do_tmo     = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stim_led <= 1'b0;
      r_ms       <= '0;
      r_delay    <= '0;
      r_result   <= '0;
      r_best     <= T_MAX;
      r_winner   <= 3'd0;
      r_false    <= 1'b0;
      r_tmo      <= 1'b0;
      r_load     <= 1'b0;
    end else begin
      r_stim_led <= (w_state_next == S_GO);
      r_load     <= 1'b0;
      if (r_state == S_ARM) begin
        r_delay <= D_MIN + 14'(r_lfsr[RAND_BITS-1:0]);
        r_ms    <= '0;
        r_false <= 1'b0;
        r_tmo   <= 1'b0;
      end else if (w_go_enter) begin
        r_ms <= '0;
      end else if ((r_state == S_WAIT || r_state == S_GO) && w_tick) begin
        r_ms <= r_ms + 1'b1;
      end
      if (w_do_fault) begin
        r_winner <= w_low;
        r_false  <= 1'b1;
      end
      if (w_do_press) begin
        r_winner <= w_low;
        r_result <= r_ms;
        r_load   <= 1'b1;
        if (r_ms < r_best) r_best <= r_ms;
      end
      if (w_do_tmo) begin
        r_winner <= 3'd0;
        r_result <= T_MAX;
        r_tmo    <= 1'b1;
        r_load   <= 1'b1;
      end
    end
  end

  // Double dabble: r_load restarts a 14-step conversion; result_bcd updates only at the end.
  logic [13:0] r_bin;
  logic [15:0] r_acc, r_bcd, w_adj;
  logic [3:0]  r_bcnt;
  logic        r_busy, r_bcd_valid;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_dig
      assign w_adj[4*gi +: 4] = (r_acc[4*gi +: 4] >= 4'd5) ? r_acc[4*gi +: 4] + 4'd3
                                                           : r_acc[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bin       <= '0;
      r_acc       <= '0;
      r_bcnt      <= '0;
      r_busy      <= 1'b0;
      r_bcd       <= '0;
      r_bcd_valid <= 1'b1;
    end else if (r_load) begin
      r_bin       <= r_result;
      r_acc       <= '0;
      r_bcnt      <= 4'd14;
      r_busy      <= 1'b1;
      r_bcd_valid <= 1'b0;
    end else if (r_busy) begin
      r_acc  <= {w_adj[14:0], r_bin[13]};
      r_bin  <= {r_bin[12:0], 1'b0};
      r_bcnt <= r_bcnt - 1'b1;
      if (r_bcnt == 4'd1) begin
        r_bcd       <= {w_adj[14:0], r_bin[13]};
        r_busy      <= 1'b0;
        r_bcd_valid <= 1'b1;
      end
    end
  end

  assign bus.stim_led    = r_stim_led;
  assign bus.result_ms   = r_result;
  assign bus.result_bcd  = r_bcd;
  assign bus.bcd_valid   = r_bcd_valid;
  assign bus.winner      = r_winner;
  assign bus.false_start = r_false;
  assign bus.timeout     = r_tmo;
  assign bus.best_ms     = r_best;
  assign bus.state_o     = r_state;
endmodule
